// File: rtl/mem_block_copier.sv
// -----------------------------------------------------------------------------
// mem_block_copier
//
// Word-granular block-copy engine acting as an initiator on a simple memory
// port (address, read, write, write data, read data). Copies a run of words
// from a source region to a destination region, strictly forward and one word
// at a time (read, then write), then pulses o_done for one cycle.
//
// The target memory has a fixed, unclocked read latency, so each read strobe
// is held for READ_WAIT cycles and the read data is sampled on the edge that
// ends the last of those cycles.
//
// Optional feature macro: MEM_BLOCK_COPIER_CHECKSUM_EN
//   When defined, o_checksum exists and accumulates the 32-bit wrapping sum of
//   every word written during the run (cleared on an accepted start).
//
// Parameters:
//   READ_WAIT  cycles mem_read is held before read data is sampled (1..15)
//   CNT_W      width of the word count
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_start          single-cycle request, sampled only while idle
//   i_src_addr       byte address of first source word ([1:0] ignored)
//   i_dst_addr       byte address of first destination word ([1:0] ignored)
//   i_word_count     number of words to copy
//   o_busy           high while a run is in progress (low in the done cycle)
//   o_done           one-cycle completion pulse
//   o_mem_addr       registered memory byte address, [1:0] always 0
//   o_mem_read       registered read strobe
//   o_mem_write      registered write strobe, one cycle per word
//   o_mem_write_data registered write data (holds its last value when idle)
//   i_mem_read_data  memory read data
//   o_checksum       wrapping sum of written words (checksum build only)
// -----------------------------------------------------------------------------
module mem_block_copier #(
  parameter int READ_WAIT = 3,
  parameter int CNT_W     = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [CNT_W-1:0] i_word_count,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_mem_addr,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [31:0]      o_mem_write_data,
  input  logic [31:0]      i_mem_read_data
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
  ,
  output logic [31:0]      o_checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Wait counter value during the final RD cycle of a word.
  localparam logic [3:0] LP_WAIT_LAST = 4'(READ_WAIT - 1);

  state_t           r_state, w_state_next;
  logic [31:0]      r_src, w_src_next;
  logic [31:0]      r_dst, w_dst_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_wait, w_wait_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic [31:0]      r_mem_addr, w_mem_addr_next;
  logic             r_mem_read, w_mem_read_next;
  logic             r_mem_write, w_mem_write_next;
  logic [31:0]      r_mem_write_data, w_mem_write_data_next;
  logic [31:0]      w_src_aligned;
  logic [31:0]      w_dst_aligned;
  logic             w_unused_addr_lsbs;

  assign w_src_aligned      = {i_src_addr[31:2], 2'b00};
  assign w_dst_aligned      = {i_dst_addr[31:2], 2'b00};
  assign w_unused_addr_lsbs = ^{i_src_addr[1:0], i_dst_addr[1:0]};

`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
  logic [31:0] r_checksum, w_checksum_next;
`endif

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_src            <= '0;
      r_dst            <= '0;
      r_cnt            <= '0;
      r_wait           <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_write_data <= '0;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
      r_checksum       <= '0;
`endif
    end else begin
      r_state          <= w_state_next;
      r_src            <= w_src_next;
      r_dst            <= w_dst_next;
      r_cnt            <= w_cnt_next;
      r_wait           <= w_wait_next;
      r_busy           <= w_busy_next;
      r_done           <= w_done_next;
      r_mem_addr       <= w_mem_addr_next;
      r_mem_read       <= w_mem_read_next;
      r_mem_write      <= w_mem_write_next;
      r_mem_write_data <= w_mem_write_data_next;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
      r_checksum       <= w_checksum_next;
`endif
    end
  end

  // Next-state logic. Outputs are registered, so each branch sets the values
  // the outputs must carry in the state being entered.
  always_comb begin
    w_state_next          = r_state;
    w_src_next            = r_src;
    w_dst_next            = r_dst;
    w_cnt_next            = r_cnt;
    w_wait_next           = r_wait;
    w_busy_next           = 1'b0;
    w_done_next           = 1'b0;
    w_mem_addr_next       = '0;
    w_mem_read_next       = 1'b0;
    w_mem_write_next      = 1'b0;
    w_mem_write_data_next = r_mem_write_data;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    w_checksum_next       = r_checksum;
`endif

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_src_next  = w_src_aligned;
          w_dst_next  = w_dst_aligned;
          w_cnt_next  = i_word_count;
          w_wait_next = '0;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
          w_checksum_next = '0;
`endif
          if (i_word_count == '0) begin
            w_state_next = S_FIN;
            w_done_next  = 1'b1;
          end else begin
            w_state_next    = S_RD;
            w_busy_next     = 1'b1;
            w_mem_read_next = 1'b1;
            w_mem_addr_next = w_src_aligned;
          end
        end
      end

      S_RD: begin
        w_busy_next = 1'b1;
        if (r_wait == LP_WAIT_LAST) begin
          // Read data has settled: capture it and present the write.
          w_state_next          = S_WR;
          w_wait_next           = '0;
          w_mem_write_data_next = i_mem_read_data;
          w_mem_write_next      = 1'b1;
          w_mem_addr_next       = r_dst;
        end else begin
          w_wait_next     = r_wait + 4'd1;
          w_mem_read_next = 1'b1;
          w_mem_addr_next = r_src;
        end
      end

      S_WR: begin
        // Pointers wrap naturally at 2^32.
        w_src_next = r_src + 32'd4;
        w_dst_next = r_dst + 32'd4;
        w_cnt_next = r_cnt - CNT_W'(1);
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
        w_checksum_next = r_checksum + r_mem_write_data;
`endif
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_FIN;
          w_done_next  = 1'b1;
        end else begin
          w_state_next    = S_RD;
          w_busy_next     = 1'b1;
          w_mem_read_next = 1'b1;
          w_mem_addr_next = r_src + 32'd4;
        end
      end

      S_FIN: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_read       = r_mem_read;
  assign o_mem_write      = r_mem_write;
  assign o_mem_write_data = r_mem_write_data;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
  assign o_checksum       = r_checksum;
`endif

endmodule

// File: tb/tb_mem_block_copier.sv
`timescale 1ns/1ps
module tb_mem_block_copier;

  localparam int RW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [9:0]  wc = '0;
  logic        busy, done, mem_read, mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_block_copier #(.READ_WAIT(RW), .CNT_W(10)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_src_addr(src),
    .i_dst_addr(dst),
    .i_word_count(wc),
    .o_busy(busy),
    .o_done(done),
    .o_mem_addr(mem_addr),
    .o_mem_read(mem_read),
    .o_mem_write(mem_write),
    .o_mem_write_data(mem_write_data),
    .i_mem_read_data(mem_read_data)
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    ,
    .o_checksum(checksum)
`endif
  );

  // Memory model: 1024 words, data valid only once mem_read has been held
  // for RW cycles; otherwise a poison value is driven.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  bit          overlap_seen = 1'b0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_write) mem[mem_addr[11:2]] <= mem_write_data;
    rd_cnt <= mem_read ? rd_cnt + 1 : 0;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_read && mem_write) overlap_seen <= 1'b1;
  end

  assign mem_read_data = (mem_read && rd_cnt >= RW - 1) ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 10'(idx); pl_val = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issues a start and returns at the cycle done is seen (posedge + 1 ns).
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [9:0] n,
                          output int lat, output logic busy1, output logic rd1);
    @(negedge clk);
    src = s; dst = d; wc = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1; busy1 = busy; rd1 = mem_read;
    while (!done && lat < 400) begin
      @(posedge clk); #1 lat++;
    end
  endtask

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [9:0]       cnt;
    logic [3:0][31:0] data;
    int               exp_lat;
    logic [31:0]      exp_sum;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    logic b1, r1;
    int w0, d0, si, di;

    vecs[0] = '{32'h0000_00C8, 32'h0000_00F0, 10'd4, {32'd44, 32'd33, 32'd22, 32'd11}, 17, 32'h0000_006E};
    vecs[1] = '{32'h0000_0040, 32'h0000_0080, 10'd0, {32'd0, 32'd0, 32'd0, 32'd0}, 1, 32'h0000_0000};
    vecs[2] = '{32'h0000_0100, 32'h0000_0200, 10'd1, {32'd0, 32'd0, 32'd0, 32'hA5A5_0001}, 5, 32'hA5A5_0001};
    vecs[3] = '{32'h0000_0003, 32'h0000_0402, 10'd2, {32'd0, 32'd0, 32'h0F0F_0F0F, 32'h1234_5678}, 9, 32'h2143_6587};
    vecs[4] = '{32'h0000_0300, 32'h0000_0380, 10'd2, {32'd0, 32'd0, 32'h0000_0002, 32'hFFFF_FFFF}, 9, 32'h0000_0001};

    // Reset state.
    #12;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_read", {31'd0, mem_read}, 32'd0);
    check("rst mem_write", {31'd0, mem_write}, 32'd0);
    check("rst wdata", mem_write_data, 32'd0);
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    check("rst checksum", checksum, 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Table-driven copies.
    for (int v = 0; v < 5; v++) begin
      si = int'(vecs[v].src[11:2]);
      di = int'(vecs[v].dst[11:2]);
      for (int i = 0; i < int'(vecs[v].cnt); i++) poke(si + i, vecs[v].data[i]);
      poke(di + int'(vecs[v].cnt), 32'h5E5E_5E5E);
      w0 = wr_cnt;
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].cnt, lat, b1, r1);
      $display("vec %0d: src=%08h dst=%08h n=%0d done after %0d cycles", v,
               vecs[v].src, vecs[v].dst, vecs[v].cnt, lat);
      check($sformatf("v%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d busy c1", v), {31'd0, b1}, (vecs[v].cnt != 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d read c1", v), {31'd0, r1}, (vecs[v].cnt != 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d busy@done", v), {31'd0, busy}, 32'd0);
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
      check($sformatf("v%0d checksum", v), checksum, vecs[v].exp_sum);
`endif
      @(posedge clk); #1;
      check($sformatf("v%0d done pulse", v), {31'd0, done}, 32'd0);
      check($sformatf("v%0d idle addr", v), mem_addr, 32'd0);
      check($sformatf("v%0d writes", v), 32'(wr_cnt - w0), 32'(vecs[v].cnt));
      for (int i = 0; i < int'(vecs[v].cnt); i++)
        check($sformatf("v%0d dst[%0d]", v, i), mem[di + i], vecs[v].data[i]);
      check($sformatf("v%0d dst guard", v), mem[di + int'(vecs[v].cnt)], 32'h5E5E_5E5E);
    end

    // Start while busy: second start at cycle 5 must be ignored.
    poke(50, 32'd11); poke(51, 32'd22); poke(52, 32'd33); poke(53, 32'd44);
    poke(0, 32'h0BAD_0BAD);
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clk);
    src = 32'h0000_00C8; dst = 32'h0000_0700; wc = 10'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge clk); #1 lat++; end
    src = 32'h0; dst = 32'h0; wc = 10'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; lat++;
    while (!done && lat < 400) begin @(posedge clk); #1 lat++; end
    $display("busy-start: done after %0d cycles", lat);
    check("busy-start latency", 32'(lat), 32'd17);
    repeat (30) @(posedge clk);
    #1;
    check("busy-start writes", 32'(wr_cnt - w0), 32'd4);
    check("busy-start dones", 32'(done_cnt - d0), 32'd1);
    check("busy-start dst[3]", mem[451], 32'd44);
    check("busy-start mem0", mem[0], 32'h0BAD_0BAD);

    // Overlapping regions, dst > src.
    poke(50, 32'd1); poke(51, 32'd2); poke(52, 32'd3);
    run_copy(32'h0000_00C8, 32'h0000_00CC, 10'd2, lat, b1, r1);
    $display("overlap: done after %0d cycles", lat);
    @(posedge clk); #1;
    check("overlap w51", mem[51], 32'd1);
    check("overlap w52", mem[52], 32'd1);

    // Address wrap past the 1024-word memory.
    poke(1023, 32'd7); poke(0, 32'd8);
    @(negedge clk);
    src = 32'h0000_0FFC; dst = 32'h0000_0800; wc = 10'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 1;
    check("wrap addr c1", mem_addr, 32'h0000_0FFC);
    repeat (4) begin @(posedge clk); #1 lat++; end
    check("wrap addr c5", mem_addr, 32'h0000_1000);
    check("wrap read c5", {31'd0, mem_read}, 32'd1);
    while (!done && lat < 400) begin @(posedge clk); #1 lat++; end
    $display("wrap: done after %0d cycles", lat);
    @(posedge clk); #1;
    check("wrap w512", mem[512], 32'd7);
    check("wrap w513", mem[513], 32'd8);

    // Reset abort during the second WR cycle (cycle 8).
    poke(320, 32'hAAAA_0001); poke(321, 32'hAAAA_0002);
    poke(384, 32'h5E5E_5E5E); poke(385, 32'h5E5E_5E5E);
    d0 = done_cnt;
    @(negedge clk);
    src = 32'h0000_0500; dst = 32'h0000_0600; wc = 10'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort wr c8", {31'd0, mem_write}, 32'd1);
    check("abort addr c8", mem_addr, 32'h0000_0604);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort write", {31'd0, mem_write}, 32'd0);
    check("abort addr", mem_addr, 32'd0);
    check("abort wdata", mem_write_data, 32'd0);
`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    check("abort checksum", checksum, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort dones", 32'(done_cnt - d0), 32'd0);
    check("abort dst0", mem[384], 32'hAAAA_0001);
    check("abort dst1", mem[385], 32'h5E5E_5E5E);

    check("read/write overlap", {31'd0, overlap_seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
